// File: rtl/multdiv.sv
// multdiv: iterative signed 32-bit multiply / divide unit.
// Multiply uses radix-4 modified Booth over 16 iterations. Divide uses
// non-restoring division on operand magnitudes over 32 iterations, and the
// sign is applied at the end.
// Optional feature macro: MULTDIV_DIV_EN. When it is defined, the divider
// datapath is compiled in. When it is undefined, every divide completes
// after one cycle with result 0 and exception 1.
module multdiv (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        data_busy
);

  // DIVZ is the single wait cycle used by divide-by-zero (and by every
  // divide when the divider is not built). It keeps the completion latency
  // at 1 cycle.
  typedef enum logic [2:0] {
    IDLE,
    MUL,
`ifdef MULTDIV_DIV_EN
    DIV,
`endif
    DIVZ,
    DONE
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;        // running product
  logic [63:0] mcand;      // sign-extended multiplicand, shifted left 2 per step
  logic [32:0] mplr;       // {multiplier, 0}; the low 3 bits form the Booth window
  logic [63:0] booth_add;
  logic        mul_ovf;

`ifdef MULTDIV_DIV_EN
  logic [33:0] rem;        // signed partial remainder
  logic [31:0] quo;        // dividend shifts out as quotient bits shift in
  logic [31:0] dvsr;       // divisor magnitude
  logic        neg;        // quotient sign
  logic        ovf;        // 0x80000000 / -1
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [33:0] rem_sh;
  logic [33:0] rem_nx;

  // Operand magnitudes and the next non-restoring remainder
  always_comb begin
    abs_a  = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    abs_b  = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
    rem_sh = {rem[32:0], quo[31]};
    rem_nx = rem[33] ? (rem_sh + {2'b00, dvsr}) : (rem_sh - {2'b00, dvsr});
  end
`endif

  // Radix-4 Booth digit selection and the product overflow test
  always_comb begin
    case (mplr[2:0])
      3'b001, 3'b010: booth_add = mcand;
      3'b011:         booth_add = mcand << 1;
      3'b100:         booth_add = -(mcand << 1);
      3'b101, 3'b110: booth_add = -mcand;
      default:        booth_add = '0;
    endcase
    mul_ovf = ~((&acc[63:31]) | ~(|acc[63:31]));
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplr           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      data_busy      <= 1'b0;
`ifdef MULTDIV_DIV_EN
      rem            <= '0;
      quo            <= '0;
      dvsr           <= '0;
      neg            <= 1'b0;
      ovf            <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      // A start in any state, including DONE, restarts from scratch.
      if (ctrl_MULT) begin
        state     <= MUL;
        data_busy <= 1'b1;
        cnt       <= '0;
        acc       <= '0;
        mcand     <= {{32{data_operandA[31]}}, data_operandA};
        mplr      <= {data_operandB, 1'b0};
      end else if (ctrl_DIV) begin
        data_busy <= 1'b1;
        cnt       <= '0;
`ifdef MULTDIV_DIV_EN
        state     <= (data_operandB == '0) ? DIVZ : DIV;
        rem       <= '0;
        quo       <= abs_a;
        dvsr      <= abs_b;
        neg       <= data_operandA[31] ^ data_operandB[31];
        ovf       <= (data_operandA == 32'h8000_0000) && (data_operandB == '1);
`else
        state     <= DIVZ;
`endif
      end else begin
        case (state)
          MUL: begin
            if (cnt == 6'd16) begin
              data_result    <= acc[31:0];
              data_exception <= mul_ovf;
              data_resultRDY <= 1'b1;
              data_busy      <= 1'b0;
              state          <= DONE;
            end else begin
              acc   <= acc + booth_add;
              mcand <= mcand << 2;
              mplr  <= {{2{mplr[32]}}, mplr[32:2]};
              cnt   <= cnt + 6'd1;
            end
          end
`ifdef MULTDIV_DIV_EN
          DIV: begin
            if (cnt == 6'd32) begin
              data_result    <= neg ? (~quo + 32'd1) : quo;
              data_exception <= ovf;
              data_resultRDY <= 1'b1;
              data_busy      <= 1'b0;
              state          <= DONE;
            end else begin
              rem <= rem_nx;
              quo <= {quo[30:0], ~rem_nx[33]};
              cnt <= cnt + 6'd1;
            end
          end
`endif
          DIVZ: begin
            data_result    <= '0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            data_busy      <= 1'b0;
            state          <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv.md
# multdiv

Iterative signed 32-bit multiply/divide unit for the execute stage of the 5-stage pipeline. It sits directly downstream of `regfile`: it consumes `data_readRegA`/`data_readRegB` as operands. Its result goes back to `regfile` through writeback. The pipeline stalls on `data_busy` and captures the result on the one-cycle `data_resultRDY` pulse.

## Interface
- No parameters; widths are fixed at 32 bits.
- `clock`  input  1  rising-edge clock; single clock domain.
- `ctrl_reset`  input  1  synchronous, active-high reset.
- `ctrl_MULT`  input  1  start signed multiply; sampled on a rising edge.
- `ctrl_DIV`  input  1  start signed divide; sampled on a rising edge.
- `data_operandA`  input  32  multiplicand / dividend, two's complement.
- `data_operandB`  input  32  multiplier / divisor, two's complement.
- `data_result`  output  32  low 32 bits of the product, or the quotient.
- `data_exception`  output  1  overflow or divide-by-zero flag; valid with `data_resultRDY`.
- `data_resultRDY`  output  1  single-cycle completion pulse.
- `data_busy`  output  1  high while an operation is in flight.

## Operation
- States:
  - IDLE: default state.
  - MUL: radix-4 modified Booth; 16 iterations.
  - DIV: non-restoring division on magnitudes; 32 iterations; sign fixed at the end.
  - DONE: lasts one cycle; asserts `data_resultRDY`, then returns to IDLE.
- Start:
  - On a rising edge with `ctrl_MULT` or `ctrl_DIV` high, the operands are latched and the FSM enters MUL or DIV.
  - If both are high, MULT wins and DIV is ignored.
- Restart: a start asserted during MUL or DIV aborts the current operation. The new operation begins from its first iteration with the new operands, and the aborted operation produces no `data_resultRDY`.
- Multiply:
  - Result is `product[31:0]`.
  - `data_exception` = 1 when the signed 64-bit product does not fit in signed 32 bits, i.e. `product[63:31]` is not all-equal.
- Divide:
  - The quotient truncates toward zero; the remainder is discarded.
  - Divisor 0: the FSM goes straight to DONE without iterating; result 0, exception 1.
  - 0x80000000 / -1: result 0x80000000, exception 1.
- `data_result` and `data_exception` hold their values from the last completion until the next completion. They do not change during iteration.
- Reset, including mid-operation: FSM goes to IDLE; all outputs become 0; internal registers are cleared; no pending `data_resultRDY` is produced.

## Timing
- Start edge = E0.
- Multiply:
  - Iterations run at E1..E16; the result registers at E17.
  - `data_resultRDY` = 1 in the cycle after E17; latency 17 cycles.
- Divide:
  - Iterations run at E1..E32; correction and result register at E33.
  - `data_resultRDY` = 1 after E33; latency 33 cycles.
- Divide by zero: `data_resultRDY` = 1 after E1; latency 1 cycle.
- `data_busy`:
  - Goes high in the cycle after E0.
  - Goes low in the same cycle that `data_resultRDY` goes high.
- A start may be issued in the DONE cycle. `data_resultRDY` still pulses for the completing op, and the new op begins at that edge.
- Reset values: `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `data_busy` = 0.

## Configuration
- Macro: `MULTDIV_DIV_EN`.
- Defined: full divider datapath (DIV state, 32-iteration non-restoring) is compiled in.
- Undefined:
  - The DIV state and the divider datapath are omitted.
  - `ctrl_DIV` (when not overridden by `ctrl_MULT`) completes at latency 1 with result 0 and exception 1.
  - Multiply behaviour and timing are unchanged.

## Test plan
- 7 × -3: result 0xFFFFFFEB, exception 0, RDY exactly 17 cycles after start, busy low thereafter.
- 0x00010000 × 0x00010000: result 0x00000000, exception 1; 0x7FFFFFFF × 1 gives result 0x7FFFFFFF, exception 0.
- Division with `MULTDIV_DIV_EN`:
  - -100 / 7: result 0xFFFFFFF2, exception 0, RDY after 33 cycles.
  - 0x80000000 / -1: result 0x80000000, exception 1.
- 5 / 0: result 0, exception 1, RDY 1 cycle after start; same response for any DIV when `MULTDIV_DIV_EN` is undefined.
- Restart and simultaneous starts:
  - Start MULT 3×4, then assert DIV 100/10 at cycle 5: no RDY for the multiply; RDY 33 cycles after the DIV start with result 10.
  - Assert MULT and DIV together with operands 6, 2: result 12 after 17 cycles.
- Assert `ctrl_reset` at cycle 10 of a multiply: all outputs 0 next cycle, no RDY pulse ever appears, and a fresh multiply completes normally.
